// File: rtl/div_seq_fx.sv
// div_seq_fx: multi-cycle signed DIV/MOD co-unit, one quotient bit per clock
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only while idle
//   op    - 5'd4 = DIV, 5'd5 = MOD; other values are ignored
//   in1   - signed dividend
//   in2   - signed divisor
//   busy  - high while an operation is in flight (RUN and FIX)
//   done  - one-cycle pulse, out/dz valid from this cycle
//   dz    - divide-by-zero flag of the last result
//   out   - signed quotient or remainder, held until the next done
//
// Optional feature: define DIV_EARLY_EN to skip the iteration phase when
// the divisor is zero or its magnitude exceeds the dividend's.
module div_seq_fx #(
    parameter int NUBITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        op,
    input  logic [NUBITS-1:0] in1,
    input  logic [NUBITS-1:0] in2,
    output logic              busy,
    output logic              done,
    output logic              dz,
    output logic [NUBITS-1:0] out
);
    localparam int CW = $clog2(NUBITS + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // rem and divisor magnitudes fit in NUBITS unsigned bits because the
    // remainder is always below the divisor and |MIN| = 2^(NUBITS-1)
    logic [NUBITS-1:0] rem_q, rem_d;
    logic [NUBITS-1:0] quo_q, quo_d;
    logic [NUBITS-1:0] dvs_q, dvs_d;
    logic              mod_q, mod_d;
    logic              neg_q, neg_d;
    logic              qneg_q, qneg_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;
    logic [NUBITS-1:0] out_q, out_d;

    logic [NUBITS-1:0] abs1, abs2, quo_res, rem_res;
    logic [NUBITS:0]   shifted;
    logic              ge, accept;

    assign abs1    = in1[NUBITS-1] ? -in1 : in1;
    assign abs2    = in2[NUBITS-1] ? -in2 : in2;
    assign accept  = start && (op == 5'd4 || op == 5'd5);
    // one restoring-division step: shift the next dividend bit into rem
    assign shifted = {rem_q, quo_q[NUBITS-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign quo_res = zero_q ? '1 : (qneg_q ? -quo_q : quo_q);
    assign rem_res = neg_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        mod_d   = mod_q;
        neg_d   = neg_q;
        qneg_d  = qneg_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        out_d   = out_q;
        if (state_q == S_IDLE) begin
            if (accept) begin
                mod_d   = op[0];
                neg_d   = in1[NUBITS-1];
                qneg_d  = in1[NUBITS-1] ^ in2[NUBITS-1];
                zero_d  = in2 == '0;
                dvs_d   = abs2;
                cnt_d   = CW'(NUBITS);
                state_d = S_RUN;
                rem_d   = '0;
                quo_d   = abs1;
`ifdef DIV_EARLY_EN
                // quotient is trivially zero: remainder is the whole dividend
                if (in2 == '0 || abs2 > abs1) begin
                    state_d = S_FIX;
                    rem_d   = abs1;
                    quo_d   = '0;
                end
`endif
            end
        end else if (state_q == S_RUN) begin
            rem_d   = ge ? NUBITS'(shifted - {1'b0, dvs_q}) : shifted[NUBITS-1:0];
            quo_d   = {quo_q[NUBITS-2:0], ge};
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CW'(1)) ? S_FIX : S_RUN;
        end else begin
            out_d   = mod_q ? rem_res : quo_res;
            dz_d    = zero_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            mod_q   <= 1'b0;
            neg_q   <= 1'b0;
            qneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            mod_q   <= mod_d;
            neg_q   <= neg_d;
            qneg_q  <= qneg_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            out_q   <= out_d;
        end
    end

    assign busy = state_q != S_IDLE;
    assign done = done_q;
    assign dz   = dz_q;
    assign out  = out_q;
endmodule

// File: tb/tb_div_seq_fx.sv
// tb_div_seq_fx: directed and randomized checks of the sequential divider
module tb_div_seq_fx;
    localparam int NUBITS = 32;
    localparam int LAT = NUBITS + 2;
`ifdef DIV_EARLY_EN
    localparam int LAT_EARLY = 2;
`else
    localparam int LAT_EARLY = NUBITS + 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [4:0]        op = '0;
    logic [NUBITS-1:0] in1 = '0;
    logic [NUBITS-1:0] in2 = '0;
    logic              busy, done, dz;
    logic [NUBITS-1:0] out;

    int n_cmp = 0;
    int n_err = 0;

    div_seq_fx #(.NUBITS(NUBITS)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .dz(dz), .out(out)
    );

    always #5 clk = ~clk;

    // lat counts clock edges from the accepting edge (inclusive) to the edge raising done
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output int lat);
        @(negedge clk);
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in1 = $urandom; in2 = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = out; z = dz;
    endtask

    task automatic test_reset;
        logic [31:0] r; logic z; int lat;
        rst = 1'b1;
        #12;
        n_cmp++;
        if ({busy, done, dz, out} !== '0) begin
            n_err++; $display("FAIL reset_init: got busy=%b done=%b dz=%b out=%h want 0", busy, done, dz, out);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        op = 5'd4; in1 = 32'd1000; in2 = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL reset_busy_before: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, out} !== '0) begin
            n_err++; $display("FAIL reset_mid: got busy=%b done=%b out=%h want 0", busy, done, out);
        end
        @(negedge clk); rst = 1'b0;
        run_op(5'd4, 32'd100, 32'd10, r, z, lat);
        n_cmp++;
        if (r !== 32'd10 || lat !== LAT) begin
            n_err++; $display("FAIL reset_after: got out=%0d lat=%0d want 10 lat=%0d", r, lat, LAT);
        end
    endtask

    task automatic test_signs;
        logic [31:0] r; logic z; int lat;
        run_op(5'd4, -32'sd7, 32'd2, r, z, lat);
        n_cmp++;
        if (r !== -32'sd3 || z !== 1'b0 || lat !== LAT) begin
            n_err++; $display("FAIL div_neg7_2: got out=%h dz=%b lat=%0d want fffffffd 0 %0d", r, z, lat, LAT);
        end
        run_op(5'd5, -32'sd7, 32'd2, r, z, lat);
        n_cmp++;
        if (r !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL mod_neg7_2: got %h want ffffffff", r);
        end
        run_op(5'd5, 32'd7, -32'sd2, r, z, lat);
        n_cmp++;
        if (r !== 32'd1) begin
            n_err++; $display("FAIL mod_7_neg2: got %h want 1", r);
        end
        run_op(5'd4, -32'sd100, -32'sd7, r, z, lat);
        n_cmp++;
        if (r !== 32'd14) begin
            n_err++; $display("FAIL div_neg_neg: got %h want e", r);
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] r; logic z; int lat;
        run_op(5'd4, 32'd5, 32'd0, r, z, lat);
        n_cmp++;
        if (r !== 32'hFFFFFFFF || z !== 1'b1 || lat !== LAT_EARLY) begin
            n_err++; $display("FAIL div_by_zero: got out=%h dz=%b lat=%0d want ffffffff 1 %0d", r, z, lat, LAT_EARLY);
        end
        run_op(5'd5, 32'd5, 32'd0, r, z, lat);
        n_cmp++;
        if (r !== 32'd5 || z !== 1'b1) begin
            n_err++; $display("FAIL mod_by_zero: got out=%h dz=%b want 5 1", r, z);
        end
        run_op(5'd5, -32'sd9, 32'd0, r, z, lat);
        n_cmp++;
        if (r !== -32'sd9 || z !== 1'b1) begin
            n_err++; $display("FAIL mod_neg_by_zero: got out=%h dz=%b want fffffff7 1", r, z);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r; logic z; int lat;
        run_op(5'd4, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
        n_cmp++;
        if (r !== 32'h80000000 || z !== 1'b0) begin
            n_err++; $display("FAIL ovf_div: got out=%h dz=%b want 80000000 0", r, z);
        end
        run_op(5'd5, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
        n_cmp++;
        if (r !== 32'd0 || z !== 1'b0) begin
            n_err++; $display("FAIL ovf_mod: got out=%h dz=%b want 0 0", r, z);
        end
    endtask

    task automatic test_handshake;
        int pulses;
        @(negedge clk);
        op = 5'd4; in1 = 32'd100; in2 = 32'd10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        op = 5'd4; in1 = 32'd50; in2 = 32'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 1 || out !== 32'd10) begin
            n_err++; $display("FAIL start_while_busy: got pulses=%0d out=%0d want 1 10", pulses, out);
        end
        @(negedge clk);
        op = 5'd2; in1 = 32'd9; in2 = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL bad_op_busy: got %b want 0", busy);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++; $display("FAIL bad_op_activity: got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic seen;
        @(negedge clk);
        op = 5'd4; in1 = 32'd64; in2 = 32'd8; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (out !== 32'd8 || lat !== LAT) begin
            n_err++; $display("FAIL b2b_first: got out=%0d lat=%0d want 8 %0d", out, lat, LAT);
        end
        op = 5'd4; in1 = 32'd81; in2 = 32'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        seen = busy;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (seen !== 1'b1 || out !== 32'd9 || lat !== LAT) begin
            n_err++; $display("FAIL b2b_second: got busy=%b out=%0d lat=%0d want 1 9 %0d", seen, out, lat, LAT);
        end
    endtask

    task automatic test_early;
        logic [31:0] r; logic z; int lat;
        run_op(5'd4, 32'd3, 32'd10, r, z, lat);
        n_cmp++;
        if (r !== 32'd0 || lat !== LAT_EARLY) begin
            n_err++; $display("FAIL early_div: got out=%0d lat=%0d want 0 %0d", r, lat, LAT_EARLY);
        end
        run_op(5'd5, -32'sd3, 32'd10, r, z, lat);
        n_cmp++;
        if (r !== -32'sd3 || lat !== LAT_EARLY) begin
            n_err++; $display("FAIL early_mod: got out=%h lat=%0d want fffffffd %0d", r, lat, LAT_EARLY);
        end
    endtask

    task automatic test_random;
        logic [31:0] r; logic z; int lat;
        logic signed [31:0] a, b, eq, er;
        for (int i = 0; i < 150; i++) begin
            a = (i % 3 == 0) ? $signed($urandom_range(0, 200)) - 100 : $signed($urandom);
            b = (i % 2 == 0) ? $signed($urandom_range(0, 40)) - 20 : $signed($urandom) >>> $urandom_range(0, 31);
            if (b == 0) b = 3;
            if (a == 32'sh80000000 && b == -1) b = 2;
            eq = a / b;
            er = a % b;
            run_op(5'd4, a, b, r, z, lat);
            n_cmp++;
            if (r !== eq || z !== 1'b0) begin
                n_err++; $display("FAIL rand_div: %0d/%0d got %0d dz=%b want %0d", a, b, $signed(r), z, eq);
            end
            run_op(5'd5, a, b, r, z, lat);
            n_cmp++;
            if (r !== er) begin
                n_err++; $display("FAIL rand_mod: %0d%%%0d got %0d want %0d", a, b, $signed(r), er);
            end
        end
    endtask

    initial begin
        test_reset;
        test_signs;
        test_div_zero;
        test_overflow;
        test_handshake;
        test_back_to_back;
        test_early;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
